pr_range_fetch_ctrl: RTL
========================

# pr_range_fetch_ctrl

Sequencer that turns an element range [start_idx, end_idx) into a series of wide memory line reads and loads each returned line into the downstream 512-bit line/64-bit element read buffer. It also drives that buffer's per-line base/bounds window. It sits between the PageRank edge/vertex fetch logic and the memory read port, keeping exactly one read outstanding. It only loads the buffer when the buffer reports empty.

## Interface
- FULL_WIDTH, 512: memory line width in bits.
- WIDTH, 64: element width; ELEMS = FULL_WIDTH/WIDTH (power of two, ≤128).
- ADDR_W, 64: byte address width.
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start_valid / start_ready  in / out  1 / 1  range request handshake.
- start_idx, end_idx  in  32 each  element indices; end is exclusive.
- base_addr  in  ADDR_W  byte address of element 0 (line aligned).
- mem_req_valid / mem_req_ready  out / in  1 / 1  read request handshake.
- mem_req_addr  out  ADDR_W  line byte address.
- mem_rvalid  in  1  one-cycle response strobe.
- mem_rdata  in  FULL_WIDTH  response line.
- buf_rready  out  1  one-cycle load strobe to buffer.
- buf_rdata  out  FULL_WIDTH  latched line.
- buf_base, buf_bounds  out  8 each  element window within line, [base,bounds).
- buf_oready  in  1  buffer non-empty.
- done  out  1  one-cycle pulse: range fully loaded and buffer drained.

## Operation
- States: IDLE, REQ, RESP, WAIT_EMPTY, LOAD, DRAIN.
- IDLE: start_ready=1. On start_valid:
  - latch cur_idx=start_idx, end_idx, base_addr.
  - If start_idx ≥ end_idx, go to DRAIN with last=1 (no memory traffic).
  - Otherwise go to REQ.
- REQ: mem_req_valid=1, mem_req_addr = base_addr + (cur_idx/ELEMS)·(FULL_WIDTH/8). The address is held stable until mem_req_ready; then go to RESP.
- RESP: on mem_rvalid, latch mem_rdata and go to WAIT_EMPTY. mem_rvalid in any other state is ignored.
- WAIT_EMPTY: when buf_oready=0, go to LOAD.
- LOAD: buf_rready=1 for exactly one cycle, with:
  - buf_base = cur_idx mod ELEMS
  - line_start = cur_idx − buf_base
  - buf_bounds = min(end_idx − line_start, ELEMS)
  - Then cur_idx ← line_start + ELEMS. If new cur_idx ≥ end_idx, set last=1 and go to DRAIN; else follow the next-line rule in Configuration.
- DRAIN: when buf_oready=0, pulse done and go to IDLE.
- Arithmetic: 32-bit unsigned; the subtraction for bounds is computed in 33 bits so no wrap occurs. buf_bounds − buf_base is always in 1..ELEMS.
- buf_rdata, buf_base and buf_bounds hold their last values outside LOAD.

## Timing
- Reset values: start_ready=0 during reset, then 1 in IDLE. mem_req_valid=0, mem_req_addr=0, buf_rready=0, buf_rdata=0, buf_base=0, buf_bounds=0, done=0. State is IDLE.
- Start accepted at edge T → mem_req_valid=1 at T+1.
- mem_rvalid at T → earliest buf_rready at T+2 (WAIT_EMPTY then LOAD).
- buf_rready is never asserted on consecutive cycles. The buffer's oready rises one cycle after the load, before any WAIT_EMPTY/DRAIN sample.
- An empty range pulses done 2 cycles after start acceptance.
- Reset mid-operation: immediately return to IDLE and force all outputs to reset values. A late mem_rvalid after reset is discarded.

## Configuration
- PR_FETCH_PREFETCH_EN defined: LOAD goes to REQ, so the next line is fetched while the buffer drains.
- Not defined: LOAD goes to a wait on buf_oready=0 before REQ; requests and drains are fully serialized.
- Loaded values and done are identical in both modes; only cycle counts differ.

## Test plan
- start=5, end=19, base_addr=0x1000, buffer drains 1 element/cycle:
  - requests 0x1000, 0x1040, 0x1080;
  - loads (base,bounds) = (5,8), (0,8), (0,3);
  - one done pulse after 14 elements.
- start=8, end=8 → no mem_req_valid, no buf_rready, done 2 cycles after accept.
- mem_req_ready held low 10 cycles → mem_req_addr stable and valid held; no second request.
- buf_oready held high 20 cycles with line ready → buf_rready stays 0 until oready falls, then a single 1-cycle strobe.
- rst_n asserted while in RESP, then mem_rvalid arrives → all outputs 0, no load, next start behaves normally.
- Define PR_FETCH_PREFETCH_EN with start=0, end=16: the second mem_req_valid asserts while buf_oready=1; without the macro it asserts only after buf_oready=0.

Source files
------------

// File: rtl/pr_range_fetch_if.sv
// Handshake/bus bundle between the range fetch sequencer, the memory read port
// and the downstream line buffer.
interface pr_range_fetch_if #(
  parameter int unsigned FULL_WIDTH = 512,
  parameter int unsigned ADDR_W     = 64
);
  logic                  start_valid;
  logic                  start_ready;
  logic [31:0]           start_idx;
  logic [31:0]           end_idx;
  logic [ADDR_W-1:0]     base_addr;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_req_addr;
  logic                  mem_rvalid;
  logic [FULL_WIDTH-1:0] mem_rdata;
  logic                  buf_rready;
  logic [FULL_WIDTH-1:0] buf_rdata;
  logic [7:0]            buf_base;
  logic [7:0]            buf_bounds;
  logic                  buf_oready;
  logic                  done;

  modport slave (
    input  start_valid, start_idx, end_idx, base_addr,
    input  mem_req_ready, mem_rvalid, mem_rdata, buf_oready,
    output start_ready, mem_req_valid, mem_req_addr,
    output buf_rready, buf_rdata, buf_base, buf_bounds, done
  );

  modport master (
    output start_valid, start_idx, end_idx, base_addr,
    output mem_req_ready, mem_rvalid, mem_rdata, buf_oready,
    input  start_ready, mem_req_valid, mem_req_addr,
    input  buf_rready, buf_rdata, buf_base, buf_bounds, done
  );
endinterface

// File: rtl/pr_range_fetch_ctrl.sv
// Turns an element range [start_idx, end_idx) into line reads, one outstanding,
// and loads each line into the element buffer. PR_FETCH_PREFETCH_EN overlaps the next request with the buffer drain.
module pr_range_fetch_ctrl #(
  parameter int unsigned FULL_WIDTH = 512,
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned ADDR_W     = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  pr_range_fetch_if.slave  bus
);
  localparam int unsigned ELEMS = FULL_WIDTH / WIDTH;
  localparam int unsigned EW    = $clog2(ELEMS);
  localparam int unsigned LB_W  = $clog2(FULL_WIDTH / 8);

  typedef enum logic [2:0] {
    IDLE, REQ, RESP, WAIT_EMPTY, LOAD, DRAIN, WAIT_DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           cur_q, cur_d;
  logic [31:0]           end_q, end_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [FULL_WIDTH-1:0] line_q, line_d;
  logic [FULL_WIDTH-1:0] rdata_q, rdata_d;
  logic [7:0]            bbase_q, bbase_d;
  logic [7:0]            bbounds_q, bbounds_d;
  logic                  done_q, done_d;

  logic [31:0] line_start;
  logic [32:0] span;
  logic [32:0] next_line;

  // Window math in 33 bits so neither the bounds span nor the next line index can wrap.
  always_comb begin
    line_start = cur_q & ~32'(ELEMS - 1);
    span       = {1'b0, end_q} - {1'b0, line_start};
    next_line  = {1'b0, line_start} + 33'(ELEMS);
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    end_d     = end_q;
    base_d    = base_q;
    addr_d    = addr_q;
    line_d    = line_q;
    rdata_d   = rdata_q;
    bbase_d   = bbase_q;
    bbounds_d = bbounds_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start_valid) begin
        cur_d   = bus.start_idx;
        end_d   = bus.end_idx;
        base_d  = bus.base_addr;
        state_d = (bus.start_idx >= bus.end_idx) ? DRAIN : REQ;
      end
      REQ:  if (bus.mem_req_ready) state_d = RESP;
      RESP: if (bus.mem_rvalid) begin
        line_d  = bus.mem_rdata;
        state_d = WAIT_EMPTY;
      end
      WAIT_EMPTY: if (!bus.buf_oready) begin
        rdata_d   = line_q;
        bbase_d   = 8'(cur_q[EW-1:0]);
        bbounds_d = (span > 33'(ELEMS)) ? 8'(ELEMS) : span[7:0];
        state_d   = LOAD;
      end
      LOAD: begin
        cur_d = next_line[31:0];
        if (next_line >= {1'b0, end_q}) state_d = DRAIN;
`ifdef PR_FETCH_PREFETCH_EN
        else                            state_d = REQ;
`else
        else                            state_d = WAIT_DRAIN;
`endif
      end
      WAIT_DRAIN: if (!bus.buf_oready) state_d = REQ;
      DRAIN: if (!bus.buf_oready) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Address is captured only on entry to REQ so it stays stable while stalled.
    if (state_d == REQ && state_q != REQ)
      addr_d = base_d + (ADDR_W'(cur_d >> EW) << LB_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      end_q     <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      line_q    <= '0;
      rdata_q   <= '0;
      bbase_q   <= '0;
      bbounds_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      end_q     <= end_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      line_q    <= line_d;
      rdata_q   <= rdata_d;
      bbase_q   <= bbase_d;
      bbounds_q <= bbounds_d;
      done_q    <= done_d;
    end
  end

  assign bus.start_ready   = rst_n && (state_q == IDLE);
  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_req_addr  = addr_q;
  assign bus.buf_rready    = (state_q == LOAD);
  assign bus.buf_rdata     = rdata_q;
  assign bus.buf_base      = bbase_q;
  assign bus.buf_bounds    = bbounds_q;
  assign bus.done          = done_q;
endmodule
